control_pipeline: RTL and testbench
===================================

// Module: control_pipeline
// PURPOSE
//  Consumer side of the decode-stage control bundle. Carries decoded control from D through E/M/W.
//  Resolves pc_src in Execute and generates hazard signals: forwarding select, load-use stall, branch flush.
//  Sits between the main/ALU decoders and the 5-stage datapath registers.
// PARAMETERS
//  ALU_CTRL_W      3      width of alu_control
//  REG_ADDR_W      5      register-file address width
//  RES_SRC_MEM     2'b01  result_src encoding for load (memory) result
// PORTS
//  clk            in   1            rising-edge clock
//  reset          in   1            synchronous, active-high
//  rs1_d, rs2_d   in   REG_ADDR_W   source regs of instruction in D
//  rd_d           in   REG_ADDR_W   dest reg of instruction in D
//  reg_write_d    in   1            D-stage control from decoder
//  result_src_d   in   2            00 ALU, 01 mem, 10 pc+4
//  mem_write_d, jump_d, branch_d, alu_src_d  in 1 each
//  alu_control_d  in   ALU_CTRL_W
//  zero_e         in   1            ALU zero flag, Execute stage
//  alu_control_e  out  ALU_CTRL_W   registered E control
//  alu_src_e      out  1
//  pc_src_e       out  1            take branch/jump target
//  mem_write_m    out  1
//  reg_write_w    out  1
//  result_src_w   out  2
//  rd_w           out  REG_ADDR_W
//  forward_a_e, forward_b_e  out 2  00 regfile, 01 W result, 10 M ALU result
//  stall_f, stall_d  out 1          hold PC and F/D register
//  flush_d        out  1            bubble F/D register
// BEHAVIOUR
//  Pipeline regs: D/E, E/M, M/W hold {reg_write,result_src,mem_write,jump,branch,alu_control,alu_src,rs1,rs2,rd}
//   as needed per stage (E: all; M: reg_write,result_src,mem_write,rd; W: reg_write,result_src,rd).
//  Reset (sync): every register -> 0 on the edge where reset=1; thereafter all outputs 0
//   (pc_src_e=0, stalls/flush 0, forwards 00). Reset mid-operation discards all in-flight control.
//  flush_e (internal) = lw_stall | pc_src_e. At edge with flush_e=1, D/E loads all-zero bubble.
//  Otherwise D/E captures D inputs; E/M and M/W always advance (never stall).
//  pc_src_e = (branch_e & zero_e) | jump_e; combinational, same cycle as zero_e.
//  lw_stall = (result_src_e==RES_SRC_MEM) & (rd_e!=0) & ((rs1_d==rd_e)|(rs2_d==rd_e)).
//  stall_f = stall_d = lw_stall & ~pc_src_e; flush_d = pc_src_e.
//   (load and branch in E are mutually exclusive; gating defines the case anyway.)
//  Load-use: exactly one stall cycle; next cycle load is in M, bubble in E, lw_stall=0, W-forward covers it.
//  forward_a_e: 10 if reg_write_m & rd_m==rs1_e & rs1_e!=0; else 01 if reg_write_w & rd_w==rs1_e
//   & rs1_e!=0; else 00. M has priority over W. forward_b_e identical on rs2_e.
//  x0 never forwarded, never causes stall. Latency D->E 1 cycle, E->M 1, M->W 1.
//  All comb outputs depend only on registered state plus rs1_d/rs2_d/zero_e; no comb path from other D inputs.
// TESTING
//  1 reset=1 one edge with arbitrary D inputs -> all outputs 0 next cycle, pc_src_e=0.
//  2 add x5 then add x6,x5,x1 -> when consumer in E, forward_a_e=10; with one nop between -> 01.
//  3 x5 written by both M and W instrs, consumer reads x5 -> forward_a_e=10 (M priority).
//  4 lw x5 then add x7,x5,x2 -> stall_f=stall_d=1 one cycle, E bubble, then forward_a_e=01; rd=x0 load -> no stall.
//  5 beq in E with zero_e=1 -> pc_src_e=1, flush_d=1, next E all-zero; zero_e=0 -> no flush. jal -> pc_src_e=1 regardless.
//  6 reset asserted while load in M and branch in E -> all regs cleared next edge, mem_write_m=0, reg_write_w=0.

Source files
------------

// File: rtl/control_pipeline.sv
// Decode-to-writeback control pipeline for the 5-stage core: carries decoded control
// through E/M/W, resolves pc_src in Execute and produces forwarding, load-use stall and flush.
module control_pipeline #(
   parameter int          ALU_CTRL_W  = 3,
   parameter int          REG_ADDR_W  = 5,
   parameter logic [1:0]  RES_SRC_MEM = 2'b01
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] rs1_d,
   input  logic [REG_ADDR_W-1:0] rs2_d,
   input  logic [REG_ADDR_W-1:0] rd_d,
   input  logic                  reg_write_d,
   input  logic [1:0]            result_src_d,
   input  logic                  mem_write_d,
   input  logic                  jump_d,
   input  logic                  branch_d,
   input  logic                  alu_src_d,
   input  logic [ALU_CTRL_W-1:0] alu_control_d,
   input  logic                  zero_e,
   output logic [ALU_CTRL_W-1:0] alu_control_e,
   output logic                  alu_src_e,
   output logic                  pc_src_e,
   output logic                  mem_write_m,
   output logic                  reg_write_w,
   output logic [1:0]            result_src_w,
   output logic [REG_ADDR_W-1:0] rd_w,
   output logic [1:0]            forward_a_e,
   output logic [1:0]            forward_b_e,
   output logic                  stall_f,
   output logic                  stall_d,
   output logic                  flush_d
);

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   // Execute-stage control
   logic                  reg_write_e;
   logic [1:0]            result_src_e;
   logic                  mem_write_e;
   logic                  jump_e;
   logic                  branch_e;
   logic [REG_ADDR_W-1:0] rs1_e;
   logic [REG_ADDR_W-1:0] rs2_e;
   logic [REG_ADDR_W-1:0] rd_e;

   // Memory-stage control
   logic                  reg_write_m;
   logic [1:0]            result_src_m;
   logic [REG_ADDR_W-1:0] rd_m;

   logic lw_stall;
   logic flush_e;

   // D/E register: a stall or a taken branch/jump turns the incoming slot into a bubble
   always_ff @(posedge clk) begin
      if (reset || flush_e) begin
         reg_write_e   <= 1'b0;
         result_src_e  <= 2'b00;
         mem_write_e   <= 1'b0;
         jump_e        <= 1'b0;
         branch_e      <= 1'b0;
         alu_control_e <= '0;
         alu_src_e     <= 1'b0;
         rs1_e         <= '0;
         rs2_e         <= '0;
         rd_e          <= '0;
      end else begin
         reg_write_e   <= reg_write_d;
         result_src_e  <= result_src_d;
         mem_write_e   <= mem_write_d;
         jump_e        <= jump_d;
         branch_e      <= branch_d;
         alu_control_e <= alu_control_d;
         alu_src_e     <= alu_src_d;
         rs1_e         <= rs1_d;
         rs2_e         <= rs2_d;
         rd_e          <= rd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         reg_write_m  <= 1'b0;
         result_src_m <= 2'b00;
         mem_write_m  <= 1'b0;
         rd_m         <= '0;
      end else begin
         reg_write_m  <= reg_write_e;
         result_src_m <= result_src_e;
         mem_write_m  <= mem_write_e;
         rd_m         <= rd_e;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         reg_write_w  <= 1'b0;
         result_src_w <= 2'b00;
         rd_w         <= '0;
      end else begin
         reg_write_w  <= reg_write_m;
         result_src_w <= result_src_m;
         rd_w         <= rd_m;
      end
   end

   assign pc_src_e = (branch_e & zero_e) | jump_e;

   assign lw_stall = (result_src_e == RES_SRC_MEM) && (rd_e != '0) &&
                     ((rs1_d == rd_e) || (rs2_d == rd_e));

   assign flush_e = lw_stall | pc_src_e;
   assign stall_f = lw_stall & ~pc_src_e;
   assign stall_d = lw_stall & ~pc_src_e;
   assign flush_d = pc_src_e;

   // Memory stage wins over writeback since it holds the younger value; x0 is never forwarded
   function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs,
                                          input logic                  wr_m,
                                          input logic [REG_ADDR_W-1:0] dst_m,
                                          input logic                  wr_w,
                                          input logic [REG_ADDR_W-1:0] dst_w);
      logic [1:0] sel;
      sel = FWD_RF;
      if (rs != '0) begin
         if (wr_m && (dst_m == rs))
            sel = FWD_M;
         else if (wr_w && (dst_w == rs))
            sel = FWD_W;
      end
      return sel;
   endfunction

   assign forward_a_e = fwd_sel(rs1_e, reg_write_m, rd_m, reg_write_w, rd_w);
   assign forward_b_e = fwd_sel(rs2_e, reg_write_m, rd_m, reg_write_w, rd_w);

endmodule

// File: tb/tb_control_pipeline.sv
// Directed bench for control_pipeline: per-cycle vector table with hand-computed
// expected outputs, plus a short reset-while-store sequence.
module tb_control_pipeline;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] rs1_d, rs2_d, rd_d;
   logic       reg_write_d;
   logic [1:0] result_src_d;
   logic       mem_write_d, jump_d, branch_d, alu_src_d;
   logic [2:0] alu_control_d;
   logic       zero_e;
   logic [2:0] alu_control_e;
   logic       alu_src_e, pc_src_e, mem_write_m, reg_write_w;
   logic [1:0] result_src_w;
   logic [4:0] rd_w;
   logic [1:0] forward_a_e, forward_b_e;
   logic       stall_f, stall_d, flush_d;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   control_pipeline dut (
      .clk(clk), .reset(reset),
      .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
      .reg_write_d(reg_write_d), .result_src_d(result_src_d),
      .mem_write_d(mem_write_d), .jump_d(jump_d), .branch_d(branch_d),
      .alu_src_d(alu_src_d), .alu_control_d(alu_control_d),
      .zero_e(zero_e),
      .alu_control_e(alu_control_e), .alu_src_e(alu_src_e), .pc_src_e(pc_src_e),
      .mem_write_m(mem_write_m), .reg_write_w(reg_write_w),
      .result_src_w(result_src_w), .rd_w(rd_w),
      .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
      .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d)
   );

   typedef struct packed {
      logic [4:0] rs1, rs2, rd;
      logic       rw;
      logic [1:0] rsrc;
      logic       mw, jmp, br, asrc;
      logic [2:0] aluc;
   } dec_t;

   typedef struct packed {
      logic [2:0] aluc_e;
      logic       asrc_e, pc_src, mw_m, rw_w;
      logic [1:0] rsrc_w;
      logic [4:0] rd_w;
      logic [1:0] fa, fb;
      logic       stall, flush;
   } exp_t;

   typedef struct packed {
      logic rst;
      dec_t d;
      logic zero;
      exp_t e;
   } vec_t;

   localparam int NV = 35;
   vec_t tbl [NV];

   function automatic dec_t nop();
      dec_t d;
      d = '0;
      return d;
   endfunction

   function automatic dec_t alu(input int rd, input int rs1, input int rs2, input int aluc);
      dec_t d;
      d = '0;
      d.rd = 5'(rd); d.rs1 = 5'(rs1); d.rs2 = 5'(rs2);
      d.rw = 1'b1; d.aluc = 3'(aluc);
      return d;
   endfunction

   function automatic dec_t lw(input int rd, input int rs1);
      dec_t d;
      d = '0;
      d.rd = 5'(rd); d.rs1 = 5'(rs1);
      d.rw = 1'b1; d.rsrc = 2'b01; d.asrc = 1'b1;
      return d;
   endfunction

   function automatic dec_t sw(input int rs1, input int rs2);
      dec_t d;
      d = '0;
      d.rs1 = 5'(rs1); d.rs2 = 5'(rs2);
      d.mw = 1'b1; d.asrc = 1'b1;
      return d;
   endfunction

   function automatic dec_t beq(input int rs1, input int rs2);
      dec_t d;
      d = '0;
      d.rs1 = 5'(rs1); d.rs2 = 5'(rs2);
      d.br = 1'b1; d.aluc = 3'd1;
      return d;
   endfunction

   function automatic dec_t jal(input int rd);
      dec_t d;
      d = '0;
      d.rd = 5'(rd); d.rw = 1'b1; d.rsrc = 2'b10; d.jmp = 1'b1;
      return d;
   endfunction

   function automatic exp_t ex(input int aluc_e, input int asrc_e, input int pc,
                               input int mw_m, input int rw_w, input int rsrc_w,
                               input int rdw, input int fa, input int fb,
                               input int st, input int fl);
      exp_t e;
      e.aluc_e = 3'(aluc_e); e.asrc_e = 1'(asrc_e); e.pc_src = 1'(pc);
      e.mw_m = 1'(mw_m); e.rw_w = 1'(rw_w); e.rsrc_w = 2'(rsrc_w);
      e.rd_w = 5'(rdw); e.fa = 2'(fa); e.fb = 2'(fb);
      e.stall = 1'(st); e.flush = 1'(fl);
      return e;
   endfunction

   function automatic vec_t row(input logic rst, input dec_t d, input logic zero, input exp_t e);
      vec_t v;
      v.rst = rst; v.d = d; v.zero = zero; v.e = e;
      return v;
   endfunction

   task automatic drive(input logic rst, input dec_t d, input logic zero);
      reset = rst;
      rs1_d = d.rs1; rs2_d = d.rs2; rd_d = d.rd;
      reg_write_d = d.rw; result_src_d = d.rsrc; mem_write_d = d.mw;
      jump_d = d.jmp; branch_d = d.br; alu_src_d = d.asrc; alu_control_d = d.aluc;
      zero_e = zero;
   endtask

   task automatic chk(input string nm, input int r, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL row %0d %s: got %0h expected %0h", r, nm, act, exp);
      end
   endtask

   task automatic chk_all(input int r, input exp_t e);
      chk("alu_control_e", r, 32'(alu_control_e), 32'(e.aluc_e));
      chk("alu_src_e",     r, 32'(alu_src_e),     32'(e.asrc_e));
      chk("pc_src_e",      r, 32'(pc_src_e),      32'(e.pc_src));
      chk("mem_write_m",   r, 32'(mem_write_m),   32'(e.mw_m));
      chk("reg_write_w",   r, 32'(reg_write_w),   32'(e.rw_w));
      chk("result_src_w",  r, 32'(result_src_w),  32'(e.rsrc_w));
      chk("rd_w",          r, 32'(rd_w),          32'(e.rd_w));
      chk("forward_a_e",   r, 32'(forward_a_e),   32'(e.fa));
      chk("forward_b_e",   r, 32'(forward_b_e),   32'(e.fb));
      chk("stall_f",       r, 32'(stall_f),       32'(e.stall));
      chk("stall_d",       r, 32'(stall_d),       32'(e.stall));
      chk("flush_d",       r, 32'(flush_d),       32'(e.flush));
   endtask

   initial begin
      dec_t junk;
      exp_t z;
      z = ex(0,0,0,0,0,0,0,0,0,0,0);
      junk = lw(5, 5);
      junk.rs2 = 5'd5; junk.mw = 1'b1; junk.jmp = 1'b1; junk.br = 1'b1; junk.aluc = 3'd7;

      // reset with garbage in D, then nothing leaks
      tbl[0]  = row(1'b1, junk,           1'b1, z);
      tbl[1]  = row(1'b0, nop(),          1'b1, z);
      // M forward, then W forward with one nop between
      tbl[2]  = row(1'b0, alu(5,1,2,2),   1'b0, z);
      tbl[3]  = row(1'b0, alu(6,5,1,2),   1'b0, ex(2,0,0,0,0,0,0,0,0,0,0));
      tbl[4]  = row(1'b0, nop(),          1'b0, ex(2,0,0,0,0,0,0,2,0,0,0));
      tbl[5]  = row(1'b0, alu(8,3,4,3),   1'b0, ex(0,0,0,0,1,0,5,0,0,0,0));
      tbl[6]  = row(1'b0, nop(),          1'b0, ex(3,0,0,0,1,0,6,0,0,0,0));
      tbl[7]  = row(1'b0, alu(9,4,8,2),   1'b0, z);
      tbl[8]  = row(1'b0, nop(),          1'b0, ex(2,0,0,0,1,0,8,0,1,0,0));
      // x5 in both M and W: M wins on both operands
      tbl[9]  = row(1'b0, alu(5,1,1,1),   1'b0, z);
      tbl[10] = row(1'b0, alu(5,2,2,1),   1'b0, ex(1,0,0,0,1,0,9,0,0,0,0));
      tbl[11] = row(1'b0, alu(10,5,5,4),  1'b0, ex(1,0,0,0,0,0,0,0,0,0,0));
      tbl[12] = row(1'b0, nop(),          1'b0, ex(4,0,0,0,1,0,5,2,2,0,0));
      // load-use: one stall, bubble in E, then W forward
      tbl[13] = row(1'b0, lw(5,1),        1'b0, ex(0,0,0,0,1,0,5,0,0,0,0));
      tbl[14] = row(1'b0, alu(7,5,2,2),   1'b0, ex(0,1,0,0,1,0,10,0,0,1,0));
      tbl[15] = row(1'b0, alu(7,5,2,2),   1'b0, z);
      tbl[16] = row(1'b0, nop(),          1'b0, ex(2,0,0,0,1,1,5,1,0,0,0));
      // load into x0: no stall, no forward of x0
      tbl[17] = row(1'b0, lw(0,1),        1'b0, z);
      tbl[18] = row(1'b0, alu(11,0,0,2),  1'b0, ex(0,1,0,0,1,0,7,0,0,0,0));
      tbl[19] = row(1'b0, nop(),          1'b0, ex(2,0,0,0,0,0,0,0,0,0,0));
      tbl[20] = row(1'b0, nop(),          1'b0, ex(0,0,0,0,1,1,0,0,0,0,0));
      // beq not taken, then taken, then jal
      tbl[21] = row(1'b0, beq(1,2),       1'b0, ex(0,0,0,0,1,0,11,0,0,0,0));
      tbl[22] = row(1'b0, alu(12,3,4,2),  1'b0, ex(1,0,0,0,0,0,0,0,0,0,0));
      tbl[23] = row(1'b0, beq(1,2),       1'b0, ex(2,0,0,0,0,0,0,0,0,0,0));
      tbl[24] = row(1'b0, alu(13,3,4,5),  1'b1, ex(1,0,1,0,0,0,0,0,0,0,1));
      tbl[25] = row(1'b0, nop(),          1'b1, ex(0,0,0,0,1,0,12,0,0,0,0));
      tbl[26] = row(1'b0, jal(1),         1'b0, z);
      tbl[27] = row(1'b0, alu(14,1,1,6),  1'b0, ex(0,0,1,0,0,0,0,0,0,0,1));
      tbl[28] = row(1'b0, nop(),          1'b0, z);
      tbl[29] = row(1'b0, nop(),          1'b0, ex(0,0,0,0,1,2,1,0,0,0,0));
      // reset while load in M and branch in E
      tbl[30] = row(1'b0, sw(1,2),        1'b0, z);
      tbl[31] = row(1'b0, lw(6,1),        1'b0, ex(0,1,0,0,0,0,0,0,0,0,0));
      tbl[32] = row(1'b0, beq(3,4),       1'b0, ex(0,1,0,1,0,0,0,0,0,0,0));
      tbl[33] = row(1'b1, alu(9,6,6,2),   1'b1, ex(1,0,1,0,0,0,0,0,0,0,1));
      tbl[34] = row(1'b0, nop(),          1'b1, z);

      drive(1'b1, junk, 1'b1);
      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < NV; i++) begin
         drive(tbl[i].rst, tbl[i].d, tbl[i].zero);
         #1;
         chk_all(i, tbl[i].e);
         @(posedge clk);
         #1;
      end

      // store reaches M, then reset clears it
      drive(1'b0, sw(3,4), 1'b0);
      @(posedge clk); #1;
      drive(1'b0, nop(), 1'b0);
      @(posedge clk); #1;
      chk("seq mem_write_m before reset", 100, 32'(mem_write_m), 32'd1);
      drive(1'b1, alu(4,4,4,3), 1'b0);
      @(posedge clk); #1;
      drive(1'b0, nop(), 1'b0);
      #1;
      chk("seq mem_write_m after reset", 101, 32'(mem_write_m), 32'd0);
      chk("seq alu_control_e after reset", 101, 32'(alu_control_e), 32'd0);
      chk("seq reg_write_w after reset", 101, 32'(reg_write_w), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
